// File: rtl/segre_mem_arbiter_if.sv
// Cache-miss and memory-port bundle for the memory arbiter.
// master: the arbiter; slave: the caches and memory around it.
interface segre_mem_arbiter_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int INDEX_SIZE = 2
);
    logic                  ic_miss_i;
    logic [ADDR_SIZE-1:0]  ic_addr_i;
    logic                  ic_fill_o;
    logic [LANE_SIZE-1:0]  ic_fill_data_o;
    logic [INDEX_SIZE-1:0] ic_fill_index_o;

    logic                  dc_miss_i;
    logic [ADDR_SIZE-1:0]  dc_addr_i;
    logic                  dc_dirty_i;
    logic [ADDR_SIZE-1:0]  dc_wb_addr_i;
    logic [LANE_SIZE-1:0]  dc_wb_data_i;
    logic                  dc_fill_o;
    logic [LANE_SIZE-1:0]  dc_fill_data_o;
    logic [INDEX_SIZE-1:0] dc_fill_index_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_SIZE-1:0]  mem_addr_o;
    logic [LANE_SIZE-1:0]  mem_wr_data_o;
    logic                  mem_ready_i;
    logic [LANE_SIZE-1:0]  mem_rd_data_i;

    modport master (
        input  ic_miss_i, ic_addr_i,
        output ic_fill_o, ic_fill_data_o,
        output ic_fill_index_o,
        input  dc_miss_i, dc_addr_i, dc_dirty_i,
        input  dc_wb_addr_i, dc_wb_data_i,
        output dc_fill_o, dc_fill_data_o,
        output dc_fill_index_o,
        output mem_req_o, mem_we_o,
        output mem_addr_o, mem_wr_data_o,
        input  mem_ready_i, mem_rd_data_i
    );

    modport slave (
        output ic_miss_i, ic_addr_i,
        input  ic_fill_o, ic_fill_data_o,
        input  ic_fill_index_o,
        output dc_miss_i, dc_addr_i, dc_dirty_i,
        output dc_wb_addr_i, dc_wb_data_i,
        input  dc_fill_o, dc_fill_data_o,
        input  dc_fill_index_o,
        input  mem_req_o, mem_we_o,
        input  mem_addr_o, mem_wr_data_o,
        output mem_ready_i, mem_rd_data_i
    );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Shares one memory port between icache and dcache misses:
// optional writeback, line read, one-cycle refill with victim index.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int INDEX_SIZE = 2,
    parameter int BYTE_SIZE  = 4
) (
    input logic clk_i,
    input logic rsn_i,
    segre_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE, DC_WB, MEM_RD, FILL
    } state_t;

    localparam logic [ADDR_SIZE-1:0] LINE_MASK =
        {{(ADDR_SIZE-BYTE_SIZE){1'b1}}, {BYTE_SIZE{1'b0}}};

    state_t                state;
    logic                  last_dc;
    logic                  own_dc;
    logic                  gnt_dc;
    logic                  any_req;
    logic [ADDR_SIZE-1:0]  miss_addr;
    logic [INDEX_SIZE-1:0] ic_vic;
    logic [INDEX_SIZE-1:0] dc_vic;

    assign any_req = bus.ic_miss_i | bus.dc_miss_i;

    // On a tie the cache that did not win the previous tie goes first.
    always_comb begin
        gnt_dc = bus.dc_miss_i;
        if (bus.ic_miss_i && bus.dc_miss_i)
            gnt_dc = ~last_dc;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state               <= IDLE;
            last_dc             <= 1'b1;
            own_dc              <= 1'b0;
            miss_addr           <= '0;
            ic_vic              <= '0;
            dc_vic              <= '0;
            bus.ic_fill_o       <= 1'b0;
            bus.ic_fill_data_o  <= '0;
            bus.ic_fill_index_o <= '0;
            bus.dc_fill_o       <= 1'b0;
            bus.dc_fill_data_o  <= '0;
            bus.dc_fill_index_o <= '0;
            bus.mem_req_o       <= 1'b0;
            bus.mem_we_o        <= 1'b0;
            bus.mem_addr_o      <= '0;
            bus.mem_wr_data_o   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        own_dc        <= gnt_dc;
                        bus.mem_req_o <= 1'b1;
                        if (bus.ic_miss_i && bus.dc_miss_i)
                            last_dc <= gnt_dc;
                        miss_addr <= gnt_dc ? bus.dc_addr_i
                                            : bus.ic_addr_i;
                        if (gnt_dc && bus.dc_dirty_i) begin
                            state             <= DC_WB;
                            bus.mem_we_o      <= 1'b1;
                            bus.mem_addr_o    <=
                                bus.dc_wb_addr_i & LINE_MASK;
                            bus.mem_wr_data_o <= bus.dc_wb_data_i;
                        end else begin
                            state          <= MEM_RD;
                            bus.mem_we_o   <= 1'b0;
                            bus.mem_addr_o <= (gnt_dc ? bus.dc_addr_i
                                                      : bus.ic_addr_i)
                                              & LINE_MASK;
                        end
                    end
                end
                DC_WB: begin
                    if (bus.mem_ready_i) begin
                        state          <= MEM_RD;
                        bus.mem_we_o   <= 1'b0;
                        bus.mem_addr_o <= miss_addr & LINE_MASK;
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ready_i) begin
                        state         <= FILL;
                        bus.mem_req_o <= 1'b0;
                        if (own_dc) begin
                            bus.dc_fill_o       <= 1'b1;
                            bus.dc_fill_data_o  <= bus.mem_rd_data_i;
                            bus.dc_fill_index_o <= dc_vic;
                        end else begin
                            bus.ic_fill_o       <= 1'b1;
                            bus.ic_fill_data_o  <= bus.mem_rd_data_i;
                            bus.ic_fill_index_o <= ic_vic;
                        end
                    end
                end
                FILL: begin
                    state         <= IDLE;
                    bus.ic_fill_o <= 1'b0;
                    bus.dc_fill_o <= 1'b0;
                    if (own_dc)
                        dc_vic <= dc_vic + 1'b1;
                    else
                        ic_vic <= ic_vic + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Arbitrates instruction-cache and data-cache miss traffic onto the single shared memory port.
- Sequences each transaction: optional dirty-line writeback, then line read, then a one-cycle refill pulse into the owning cache with a victim index.
- Owns the per-cache round-robin victim counters, which supply the refill index consumed by the icache/dcache tag and data arrays.

Parameters:
- ADDR_SIZE, 32, byte address width.
- LANE_SIZE, 128, cache line width in bits.
- INDEX_SIZE, 2, cache index width. Each cache has 2^INDEX_SIZE lines.
- BYTE_SIZE, 4, log2 of line bytes. Bits below this are cleared on memory addresses.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset, asynchronous, active-low
- ic_miss_i  in  1  icache miss request, level, held until ic_fill_o
- ic_addr_i  in  ADDR_SIZE  icache miss address
- ic_fill_o  out  1  one-cycle refill strobe to icache
- ic_fill_data_o  out  LANE_SIZE  refill line for icache
- ic_fill_index_o  out  INDEX_SIZE  victim line index for icache
- dc_miss_i  in  1  dcache miss request, level, held until dc_fill_o
- dc_addr_i  in  ADDR_SIZE  dcache miss address
- dc_dirty_i  in  1  victim line is dirty; sampled at grant
- dc_wb_addr_i  in  ADDR_SIZE  victim line address
- dc_wb_data_i  in  LANE_SIZE  victim line data
- dc_fill_o  out  1  one-cycle refill strobe to dcache
- dc_fill_data_o  out  LANE_SIZE  refill line for dcache
- dc_fill_index_o  out  INDEX_SIZE  victim line index for dcache
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  1 = line write, 0 = line read
- mem_addr_o  out  ADDR_SIZE  line-aligned memory address
- mem_wr_data_o  out  LANE_SIZE  write data
- mem_ready_i  in  1  memory completion. For reads, mem_rd_data_i is valid in the same cycle.
- mem_rd_data_i  in  LANE_SIZE  read line

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, state is IDLE, both victim counters are 0, and last_grant is DC, so the icache wins the first tie. A reset asserted mid-transaction abandons it. No fill pulse is issued for the abandoned transaction.
- FSM states: IDLE, DC_WB, MEM_RD, FILL.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the one that is not last_grant (round robin), then update last_grant.
  - Grant to the dcache with dc_dirty_i=1: go to DC_WB.
  - Any other grant: go to MEM_RD.
  - No request: stay in IDLE.
  - Grant to exit takes 1 cycle. The granted address and dirty info are registered at grant.
- DC_WB:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o = dc_wb_addr_i with bits [BYTE_SIZE-1:0] cleared, mem_wr_data_o = dc_wb_data_i as registered at grant.
  - On mem_ready_i, go to MEM_RD.
- MEM_RD:
  - Outputs: mem_req_o=1, mem_we_o=0, mem_addr_o = registered miss address with bits [BYTE_SIZE-1:0] cleared.
  - On mem_ready_i, capture mem_rd_data_i and go to FILL.
- FILL (exactly 1 cycle):
  - The granted cache's fill_o=1. Its fill_data_o is the captured line; its fill_index_o is that cache's victim counter.
  - The victim counter increments at the end of FILL, wrapping from 2^INDEX_SIZE-1 to 0.
  - Next state is always IDLE. Requests are not sampled during FILL, which gives the requester a cycle to drop its miss.
- Outside FILL, fill_o=0 and fill_data_o/fill_index_o hold their last values.
- mem_addr_o, mem_we_o and mem_wr_data_o stay stable while mem_req_o=1.
- mem_ready_i in IDLE or FILL is ignored.
- A requester dropping its miss after grant does not abort the transaction. The fill pulse is still issued.
- Minimum latency, clean miss: grant cycle → MEM_RD with ready in the same cycle → FILL, i.e. fill 2 cycles after grant. A dirty miss adds at least 1 cycle.
- Back-to-back: after FILL → IDLE, a still-pending other requester is granted in that IDLE cycle.
- Only one transaction is outstanding at a time. ic_fill_o and dc_fill_o are never high together.

Test Plan:
- Reset, then ic_miss_i=1, ic_addr_i=0x0000_1234, memory ready on the 1st req cycle → mem_addr_o=0x0000_1230, mem_we_o=0; ic_fill_o pulses 1 cycle with ic_fill_index_o=0 and the data returned by memory.
- ic_miss_i and dc_miss_i raised in the same cycle after reset → icache served first, dcache second; the next simultaneous pair goes dcache then icache.
- dc_miss_i with dc_dirty_i=1, dc_wb_addr_i=0x0000_2040, dc_addr_i=0x0000_3000 → a write to 0x0000_2040 with the victim data, then a read of 0x0000_3000, then dc_fill_o; mem_req_o drops only in the FILL cycle.
- Four consecutive icache misses → ic_fill_index_o = 0,1,2,3; a fifth miss → 0 (wrap-around).
- Memory ready delayed 5 cycles → mem_req_o and mem_addr_o stay stable for all 5 cycles; no fill before mem_ready_i; a stray mem_ready_i while IDLE causes no state change.
- rsn_i pulsed low during MEM_RD → all outputs 0 immediately; no fill pulse; after release, a fresh ic_miss_i is served normally with index 0.
